accum_key_conditioner: RTL and testbench
========================================

ACCUM_KEY_CONDITIONER -- requirements
Module: accum_key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles required to accept a press or release (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, held-key auto-repeat interval; used only when ACCUM_AUTOREPEAT_EN is defined.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port key_n, input, 1, raw pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port ack, input, 1, single-cycle CPU acknowledge from an output PIO bit.
REQ-007 SHALL have port accum_out, output, 1, sticky "accumulate requested" level that drives the 1-bit PIO in_port.
REQ-008 SHALL have port press_pulse, output, 1, one-cycle strobe per accepted press.
REQ-009 SHALL have port key_state, output, 1, debounced key level, 1 = pressed.

Function
REQ-010 SHALL pass key_n through a 2-flop synchronizer; internal key_s = ~synchronized key_n; synchronizer latency is 2 cycles.
REQ-011 SHALL implement FSM states IDLE, DB_PRESS, HELD, DB_REL.
REQ-012 IDLE: key_s=1 -> DB_PRESS with counter cleared to 0; otherwise remain in IDLE.
REQ-013 DB_PRESS: key_s=0 -> IDLE (glitch rejected, no outputs change); counter == DEBOUNCE_CYCLES-1 with key_s=1 -> HELD; otherwise counter increments.
REQ-014 On the DB_PRESS->HELD transition, the next cycle SHALL show key_state=1, accum_out=1, and press_pulse=1 for exactly one cycle.
REQ-015 HELD: key_s=0 -> DB_REL with counter cleared; otherwise remain in HELD.
REQ-016 DB_REL: key_s=1 -> HELD (bounce, no new press_pulse); counter == DEBOUNCE_CYCLES-1 with key_s=0 -> IDLE and key_state=0.
REQ-017 accum_out SHALL remain set until a cycle with ack=1 clears it; release of the key SHALL NOT clear it.
REQ-018 If set and ack occur in the same cycle, set SHALL win and accum_out SHALL remain 1.
REQ-019 ack while accum_out=0 SHALL be ignored; multiple presses before ack SHALL merge into a single accum_out=1 (no count).
REQ-020 The counter SHALL be 20 bits wide, SHALL saturate and never wrap, and SHALL be cleared on every state transition.
REQ-021 Press-to-accum_out latency from a clean key_n fall SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-022 While reset_n=0: FSM=IDLE, counter=0, synchronizer flops=1 (key released), accum_out=0, press_pulse=0, key_state=0.
REQ-023 Reset asserted mid-debounce or in HELD SHALL abort immediately; after deassertion a still-held key SHALL be re-debounced from IDLE as a fresh press.

Configuration
REQ-024 Macro ACCUM_AUTOREPEAT_EN: when defined, HELD SHALL count to REPEAT_CYCLES-1, then assert press_pulse for one cycle, set accum_out, restart the counter, and repeat while the key is held.
REQ-025 Without ACCUM_AUTOREPEAT_EN, HELD SHALL generate no pulses, REPEAT_CYCLES SHALL be unused, and the repeat logic SHALL be absent.

Structure
REQ-026 Package accum_key_pkg SHALL hold the FSM state enum typedef, the counter width constant (20), and the default DEBOUNCE_CYCLES/REPEAT_CYCLES values.
REQ-027 Sub-module sync_2ff (generic 1-bit two-flop synchronizer, reset value parameterized) SHALL be instantiated for key_n.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-028 Clean press: key_n falls at cycle 0 and is held -> accum_out=1 and press_pulse=1 at cycle 7 only; key_state=1 from cycle 7.
REQ-029 Glitch: key_n low for 3 cycles, then high -> accum_out, press_pulse, and key_state stay 0 throughout.
REQ-030 Bounce on release: after HELD, key_n high 2 cycles, low 1, high steady -> exactly one press_pulse in total; key_state=0 only after 4 stable released cycles.
REQ-031 Ack race: ack pulsed in the set cycle -> accum_out=1; ack pulsed 3 cycles later -> accum_out=0 the next cycle.
REQ-032 Reset mid-HELD: reset_n low 2 cycles with key still held -> all outputs 0; after release of reset, a new press_pulse appears 7 cycles after reset deassertion.
REQ-033 With ACCUM_AUTOREPEAT_EN: key held 40 cycles after accept -> press_pulses at cycles accept+10, +20, +30; no pulses when the macro is undefined.

Source files
------------

// File: rtl/accum_key_pkg.sv
// Shared types and constants for the accumulate-key conditioner.
// Contents: debounce FSM state enum, counter width, default timing
// parameters, and a saturating-increment helper for the debounce counter.
package accum_key_pkg;

    localparam int unsigned CNT_W               = 20;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } key_fsm_e;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a parameterized reset value.
// Ports:
//   clk       - destination clock
//   reset_n   - asynchronous active-low reset (both flops load RESET_VAL)
//   d         - asynchronous input
//   q         - synchronized output, two cycles of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state: plain shift of the input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/accum_key_conditioner.sv
// Debounces an active-low pushbutton and turns each accepted press into a
// one-cycle strobe plus a sticky "accumulate requested" level for a CPU PIO.
// The sticky level is cleared only by a CPU ack; a simultaneous new press wins.
// Optional feature: define ACCUM_AUTOREPEAT_EN to re-fire the press every
// REPEAT_CYCLES while the key stays held.
// Ports:
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   key_n       - raw pushbutton, active-low, asynchronous to clk
//   ack         - single-cycle CPU acknowledge, clears accum_out
//   accum_out   - sticky accumulate request (PIO in_port)
//   press_pulse - one-cycle strobe per accepted press (or auto-repeat)
//   key_state   - debounced key level, 1 = pressed
module accum_key_conditioner
    import accum_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    input  logic ack,
    output logic accum_out,
    output logic press_pulse,
    output logic key_state
);

    // Elaboration-time guard on the timing parameters.
    if (DEBOUNCE_CYCLES < 32'd2 || DEBOUNCE_CYCLES > 32'd1048576 || REPEAT_CYCLES < 32'd2) begin : g_bad_params
        $error("accum_key_conditioner: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic     key_sync_n;
    logic     key_s;
    key_fsm_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic     key_state_q, key_state_d;
    logic     accum_q, accum_d;
    logic     pulse_q, pulse_d;
    logic     press_set;
    logic     rpt_fire;

    // Synchronizer resets to "released" so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_key_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (key_n),
        .q       (key_sync_n)
    );

    assign key_s = ~key_sync_n;

    // Debounce FSM: a press/release is accepted after DEBOUNCE_CYCLES stable
    // samples; any disagreeing sample during debounce returns to the old state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_set   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_s) begin
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    key_state_d = 1'b1;
                    press_set   = 1'b1;
                end else begin
                    cnt_d = cnt_inc_sat(cnt_q);
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!key_s) begin
                    state_d = DB_REL;
                end
            end
            DB_REL: begin
                if (key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_sat(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef ACCUM_AUTOREPEAT_EN
    // Repeat interval can exceed the 20-bit debounce counter, so it gets its own.
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 32'd1);

    logic [RPT_W-1:0] rpt_q, rpt_d;

    // Counts held cycles; restarts on every fire and on leaving HELD.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q == HELD && key_s) begin
            if (rpt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Strobe and sticky request; a set in the same cycle as ack wins.
    always_comb begin
        pulse_d = press_set | rpt_fire;
        accum_d = pulse_d | (accum_q & ~ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            accum_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            accum_q     <= accum_d;
            pulse_q     <= pulse_d;
        end
    end

    assign accum_out   = accum_q;
    assign press_pulse = pulse_q;
    assign key_state   = key_state_q;

endmodule

// File: tb/tb_accum_key_conditioner.sv
// Testbench for accum_key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10).
// Directed scenarios plus a randomized key/ack phase, all compared each cycle
// against a run-length reference model of the debounce behaviour.
module tb_accum_key_conditioner;

    localparam int unsigned DB  = 4;
    localparam int unsigned RPT = 10;

    logic clk;
    logic reset_n;
    logic key_n;
    logic ack;
    logic accum_out;
    logic press_pulse;
    logic key_state;

    int n_checks;
    int n_errors;

    // Reference model state
    logic m_d1, m_d2;     // two-sample delay of key_n (released = 1)
    logic m_level;        // accepted key level
    int   m_run;          // consecutive samples disagreeing with m_level
    int   m_rep;          // held samples since last press/repeat
    logic m_accum;
    logic m_pulse;

    accum_key_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .ack         (ack),
        .accum_out   (accum_out),
        .press_pulse (press_pulse),
        .key_state   (key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = 1'b1; m_d2 = 1'b1;
        m_level = 1'b0; m_run = 0; m_rep = 0;
        m_accum = 1'b0; m_pulse = 1'b0;
    endtask

    // One clock edge of the model: a level change is accepted once DB+1
    // consecutive samples disagree with the current level.
    task automatic model_edge(input logic kn, input logic a);
        logic ks;
        ks = ~m_d2;
        m_d2 = m_d1;
        m_d1 = kn;
        m_pulse = 1'b0;
        if (ks != m_level) begin
            m_rep = 0;
            m_run++;
            if (m_run == int'(DB) + 1) begin
                m_level = ks;
                m_run = 0;
                if (ks) m_pulse = 1'b1;
            end
        end else if (m_run != 0) begin
            m_run = 0;
            m_rep = 0;
        end else if (m_level) begin
`ifdef ACCUM_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == int'(RPT)) begin
                m_pulse = 1'b1;
                m_rep = 0;
            end
`endif
        end
        if (m_pulse) m_accum = 1'b1;
        else if (a)  m_accum = 1'b0;
    endtask

    task automatic check_outputs();
        chk("press_pulse", int'(press_pulse), int'(m_pulse));
        chk("accum_out",   int'(accum_out),   int'(m_accum));
        chk("key_state",   int'(key_state),   int'(m_level));
    endtask

    // Drive inputs for one cycle, advance the model at the edge, check after it.
    task automatic step(input logic kn, input logic a);
        key_n = kn;
        ack   = a;
        @(posedge clk);
        model_edge(kn, a);
        #1;
        check_outputs();
    endtask

    // Hold reset for n edges, checking outputs are all zero throughout.
    task automatic do_reset(input int n, input logic kn);
        key_n = kn;
        ack = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pulse", int'(press_pulse), 0);
        chk("rst_accum", int'(accum_out), 0);
        chk("rst_state", int'(key_state), 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int first;
        int pulses;
        int seg_len;
        logic seg_lvl;

        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b1;
        key_n = 1'b1;
        ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, then idle
        do_reset(3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Clean press: strobe exactly 7 cycles after the key_n fall
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse && first < 0) first = i;
        end
        chk("press_latency", first, 7);

        // Held key: repeat pulses only when auto-repeat is built in
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse) pulses++;
        end
`ifdef ACCUM_AUTOREPEAT_EN
        chk("held_repeat_pulses", pulses, 3);
`else
        chk("held_repeat_pulses", pulses, 0);
`endif

        // Bounce on release: no new press, level drops only after debounce
        pulses = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0);
            if (press_pulse) pulses++;
        end
        chk("release_bounce_pulses", pulses, 0);
        chk("released_state", int'(key_state), 0);

        // Ack clears the sticky request; release alone did not
        chk("accum_survives_release", int'(accum_out), 1);
        step(1'b1, 1'b1);
        chk("ack_clears", int'(accum_out), 0);
        step(1'b1, 1'b1);
        chk("ack_ignored_when_clear", int'(accum_out), 0);

        // Glitch: 3 low cycles are rejected
        pulses = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (press_pulse || key_state || accum_out) pulses++;
        end
        chk("glitch_rejected", pulses, 0);

        // Ack in the set cycle: set wins; ack 3 cycles later clears
        for (int i = 1; i <= 7; i++) step(1'b0, (i == 7) ? 1'b1 : 1'b0);
        chk("race_pulse", int'(press_pulse), 1);
        chk("race_set_wins", int'(accum_out), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("late_ack_clears", int'(accum_out), 0);

        // Reset mid-HELD with key still down: fresh press after deassertion
        do_reset(2, 1'b0);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse && first < 0) first = i;
        end
        chk("post_reset_latency", first, 7);

        // Merge: two presses without ack leave a single sticky level
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("merged_accum", int'(accum_out), 1);

        // Randomized key segments and sporadic ack
        for (int s = 0; s < 120; s++) begin
            seg_len = int'($urandom_range(1, 12));
            seg_lvl = 1'($urandom_range(0, 1));
            for (int i = 0; i < seg_len; i++) begin
                step(seg_lvl, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
            if ($urandom_range(0, 59) == 0) begin
                do_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
